// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to TRIGGER_ADDR copies one 256-byte page to the PPU OAM data port.
// Runs for 770 cycles, or 771 on odd parity; no backpressure, and once started it runs to completion or reset.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] snoop_addr,
  input  logic [7:0]  snoop_data,
  input  logic        snoop_write_en,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_data_in,
  output logic [7:0]  dma_data_out,
  output logic        dma_write_en,
  output logic        accessing_memory,
  output logic        halt,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ALIGN2,
    S_RD_ADDR,
    S_RD_WAIT,
    S_WR,
    S_FINISH
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic        par_q;
  logic        odd_q, odd_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        trig;

  assign trig = snoop_write_en && (snoop_addr == TRIGGER_ADDR);

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    odd_d   = odd_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_ALIGN;
          page_d  = snoop_data;
          idx_d   = 8'h00;
          odd_d   = par_q;
        end
      end
      S_ALIGN:   state_d = odd_q ? S_ALIGN2 : S_RD_ADDR;
      S_ALIGN2:  state_d = S_RD_ADDR;
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_WR;
      S_WR: begin
        // Index wraps within the page; the decision uses the pre-increment value.
        idx_d   = idx_q + 8'h01;
        state_d = (idx_q == 8'hFF) ? S_FINISH : S_RD_ADDR;
      end
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    addr_d = 16'h0000;
    dout_d = 8'h00;
    we_d   = 1'b0;
    case (state_d)
      S_RD_ADDR, S_RD_WAIT: addr_d = {page_d, idx_d};
      S_WR: begin
        addr_d = OAM_DATA_ADDR;
        dout_d = dma_data_in;
        we_d   = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      par_q   <= 1'b0;
      odd_q   <= 1'b0;
      addr_q  <= 16'h0000;
      dout_q  <= 8'h00;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      par_q   <= ~par_q;
      odd_q   <= odd_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dma_addr         = addr_q;
  assign dma_data_out     = dout_q;
  assign dma_write_en     = we_q;
  assign accessing_memory = busy_q;
  assign halt             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboarded bench for oam_dma: expected OAM writes are queued at trigger and popped by a monitor.
module tb_oam_dma;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] snoop_addr = 16'h0000;
  logic [7:0]  snoop_data = 8'h00;
  logic        snoop_write_en = 1'b0;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_in;
  logic [7:0]  dma_data_out;
  logic        dma_write_en;
  logic        accessing_memory;
  logic        halt;
  logic        done;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk              (clk),
    .rst              (rst),
    .snoop_addr       (snoop_addr),
    .snoop_data       (snoop_data),
    .snoop_write_en   (snoop_write_en),
    .dma_addr         (dma_addr),
    .dma_data_in      (dma_data_in),
    .dma_data_out     (dma_data_out),
    .dma_write_en     (dma_write_en),
    .accessing_memory (accessing_memory),
    .halt             (halt),
    .done             (done)
  );

  // Memory contents: page 02 holds 0..255, other pages are distinguishable by an XOR tag.
  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] - 8'h02);
  endfunction

  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) rd_q <= memf(dma_addr);
  assign dma_data_in = rd_q;

  int unsigned edge_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_front;
  logic [7:0] page_exp = 8'h00;
  int halt_cnt = 0, done_cnt = 0, first_rd = -1, wr_seen = 0;
  int acc_mis = 0, idle_viol = 0, zero_rd = 0, max_rd = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (accessing_memory !== halt) acc_mis++;
      if (!halt && (dma_addr != 16'h0 || dma_data_out != 8'h0 || dma_write_en)) idle_viol++;
      if (halt) halt_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_we_low", int'(dma_write_en), 0);
        chk("done_in_busy", int'(halt), 1);
      end
      if (halt && !dma_write_en && dma_addr[15:8] == page_exp) begin
        if (first_rd < 0) first_rd = halt_cnt;
        if (int'(dma_addr) > max_rd) max_rd = int'(dma_addr);
      end
      if (halt && !dma_write_en && !done && dma_addr == 16'h0 && first_rd >= 0) zero_rd++;
      if (dma_write_en) begin
        chk("wr_addr", int'(dma_addr), 16'h2004);
        chk("wr_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_front = exp_q.pop_front();
          chk("wr_data", int'(dma_data_out), int'(exp_front));
        end
        wr_seen++;
      end
    end
  end

  task automatic start(input logic [7:0] pg, input bit par);
    do @(negedge clk); while (edge_cnt[0] != par);
    page_exp = pg;
    halt_cnt = 0; done_cnt = 0; first_rd = -1; max_rd = 0; zero_rd = 0;
    wr_seen = 0; acc_mis = 0; idle_viol = 0;
    for (int i = 0; i < 256; i++) exp_q.push_back(memf({pg, 8'(i)}));
    snoop_addr = 16'h4014; snoop_data = pg; snoop_write_en = 1'b1;
    @(posedge clk); #1;
    snoop_write_en = 1'b0; snoop_addr = 16'h0; snoop_data = 8'h0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin @(negedge clk); n++; end
    chk({name, "_done_seen"}, int'(done_cnt > 0), 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_writes(input string name, input int cnt);
    int n = 0;
    while (wr_seen < cnt && n < 2000) begin @(negedge clk); n++; end
    chk({name, "_reached"}, int'(wr_seen >= cnt), 1);
  endtask

  task automatic check_xfer(input string name, input int par);
    chk({name, "_halt_len"}, halt_cnt, 770 + par);
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_first_rd"}, first_rd, 2 + par);
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_acc_eq_halt"}, acc_mis, 0);
    chk({name, "_idle_zero"}, idle_viol, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", int'(dma_addr), 0);
    chk("rst_dout", int'(dma_data_out), 0);
    chk("rst_we", int'(dma_write_en), 0);
    chk("rst_halt", int'(halt), 0);
    chk("rst_acc", int'(accessing_memory), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    start(8'h02, 1'b0); wait_done("basic"); check_xfer("basic", 0);
    start(8'h02, 1'b1); wait_done("odd"); check_xfer("odd", 1);

    start(8'hFF, 1'b0); wait_done("wrap"); check_xfer("wrap", 0);
    chk("wrap_last_rd", max_rd, 16'hFFFF);
    chk("wrap_zero_rd", zero_rd, 0);

    start(8'h02, 1'b0);
    wait_writes("retrig", 100);
    @(negedge clk);
    snoop_addr = 16'h4014; snoop_data = 8'h05; snoop_write_en = 1'b1;
    @(posedge clk); #1;
    snoop_write_en = 1'b0; snoop_addr = 16'h0; snoop_data = 8'h0;
    wait_done("retrig"); check_xfer("retrig", 0);
    repeat (30) @(negedge clk);
    chk("retrig_no_second_halt", halt_cnt, 770);
    chk("retrig_no_second_done", done_cnt, 1);

    start(8'h02, 1'b0);
    wait_writes("rstmid", 50);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_addr", int'(dma_addr), 0);
    chk("rstmid_dout", int'(dma_data_out), 0);
    chk("rstmid_we", int'(dma_write_en), 0);
    chk("rstmid_halt", int'(halt), 0);
    chk("rstmid_acc", int'(accessing_memory), 0);
    chk("rstmid_done", int'(done), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wr_seen = 0; halt_cnt = 0; done_cnt = 0;
    repeat (40) @(negedge clk);
    chk("rstmid_no_resume_wr", wr_seen, 0);
    chk("rstmid_no_resume_halt", halt_cnt, 0);
    start(8'h02, 1'b1); wait_done("after_rst"); check_xfer("after_rst", 1);

    halt_cnt = 0; wr_seen = 0; idle_viol = 0;
    @(negedge clk);
    snoop_addr = 16'h4015; snoop_data = 8'h02; snoop_write_en = 1'b1;
    @(negedge clk);
    snoop_addr = 16'h4014; snoop_write_en = 1'b0;
    repeat (2) @(negedge clk);
    snoop_addr = 16'h0; snoop_data = 8'h0;
    repeat (20) @(negedge clk);
    chk("nontrig_halt", halt_cnt, 0);
    chk("nontrig_wr", wr_seen, 0);
    chk("nontrig_bus", idle_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
